cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 152 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Single-grant Common Data Bus arbiter: oldest-first by ROB age when CDB_AGE_PRIORITY_EN
// is defined, round-robin otherwise. Registered cdb_data/grant_id/starve_flag outputs.
module cdb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ROB_SIZE    = 4,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = $clog2(ROB_SIZE + 1),
  parameter int CDB_DATA    = 1 + ROB_TAG_LEN + XLEN,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ROB_TAG_LEN-1:0]         head,
  input  logic                           kill,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ROB_TAG_LEN-1:0] req_rob_tag,
  input  logic [NUM_REQ*XLEN-1:0]        req_value,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [CDB_DATA-1:0]            cdb_data,
  output logic [ID_W-1:0]                grant_id,
  output logic                           starve_flag
);

  localparam int AGE_W = ROB_TAG_LEN + 1;

  // Handshake: a port raises req_valid with a stable tag/value and holds them until it
  // sees req_ack high; the result is taken at the posedge closing that ack cycle.

  logic [ROB_TAG_LEN-1:0] tag   [NUM_REQ];
  logic [XLEN-1:0]        value [NUM_REQ];
  logic [NUM_REQ-1:0]     eligible;
  logic                   found;
  logic [ID_W-1:0]        sel;
  logic                   grant_valid;
  logic [ID_W-1:0]        rr_ptr;
  logic [2:0]             wait_cnt [NUM_REQ];
  logic                   starve_next;
  logic                   cdb_valid;
  logic [ROB_TAG_LEN-1:0] cdb_tag;
  logic [XLEN-1:0]        cdb_value;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tag[i]      = req_rob_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
      value[i]    = req_value[i*XLEN +: XLEN];
      eligible[i] = req_valid[i] && (tag[i] != '0);
    end
  end

`ifdef CDB_AGE_PRIORITY_EN
  localparam logic [AGE_W-1:0] ROB_SIZE_A = AGE_W'(ROB_SIZE);
  logic [AGE_W-1:0] age [NUM_REQ];
  logic [AGE_W-1:0] head_ext;
  logic [AGE_W-1:0] best_age;
  logic             unused_rr;

  assign head_ext  = {1'b0, head};
  assign unused_rr = ^rr_ptr;

  // Distance from the head, wrapping tag ROB_SIZE back around to tag 1.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if ({1'b0, tag[i]} >= head_ext)
        age[i] = {1'b0, tag[i]} - head_ext;
      else
        age[i] = {1'b0, tag[i]} + ROB_SIZE_A - head_ext;
    end
  end

  // Strict less-than keeps the lowest index on an age tie.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    best_age = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eligible[i] && (!found || age[i] < best_age)) begin
        found    = 1'b1;
        sel      = ID_W'(i);
        best_age = age[i];
      end
    end
  end
`else
  logic [ID_W-1:0] rr_idx;
  logic            unused_head;

  assign unused_head = ^head;

  always_comb begin
    found  = 1'b0;
    sel    = '0;
    rr_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && eligible[rr_idx]) begin
        found = 1'b1;
        sel   = rr_idx;
      end
    end
  end
`endif

  assign grant_valid = found && !kill && !reset;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      req_ack[i] = grant_valid && (sel == ID_W'(i));
  end

  always_comb begin
    starve_next = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (eligible[i] && !req_ack[i] && (wait_cnt[i] == 3'd7))
        starve_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      grant_id    <= '0;
      starve_flag <= 1'b0;
      rr_ptr      <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        wait_cnt[i] <= 3'd0;
    end else begin
      cdb_valid   <= grant_valid;
      starve_flag <= starve_next;
      if (grant_valid) begin
        cdb_tag   <= tag[sel];
        cdb_value <= value[sel];
        grant_id  <= sel;
`ifndef CDB_AGE_PRIORITY_EN
        if (sel == ID_W'(NUM_REQ - 1))
          rr_ptr <= '0;
        else
          rr_ptr <= sel + 1'b1;
`endif
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!eligible[i] || req_ack[i])
          wait_cnt[i] <= 3'd0;
        else if (wait_cnt[i] != 3'd7)
          wait_cnt[i] <= wait_cnt[i] + 3'd1;
      end
    end
  end

  assign cdb_data = {cdb_valid, cdb_tag, cdb_value};

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table plus hand sequences for starvation, tag 0 and reset.
// Expectations follow whichever selection mode CDB_AGE_PRIORITY_EN picks.
module tb_cdb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ROB_SIZE = 4;
  localparam int XLEN = 32;
  localparam int TL = 3;
  localparam int CW = 1 + TL + XLEN;

  logic                 clock;
  logic                 reset;
  logic [TL-1:0]        head;
  logic                 kill;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*TL-1:0] req_rob_tag;
  logic [NUM_REQ*XLEN-1:0] req_value;
  logic [NUM_REQ-1:0]   req_ack;
  logic [CW-1:0]        cdb_data;
  logic [1:0]           grant_id;
  logic                 starve_flag;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_SIZE(ROB_SIZE), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .head(head), .kill(kill),
    .req_valid(req_valid), .req_rob_tag(req_rob_tag), .req_value(req_value),
    .req_ack(req_ack), .cdb_data(cdb_data), .grant_id(grant_id), .starve_flag(starve_flag)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [TL-1:0]     head;
    logic              kill;
    logic [3:0]        valid;
    logic [4*TL-1:0]   tags;
    logic [3:0]        ack_rr;
    logic [3:0]        ack_age;
  } vec_t;

  vec_t vecs[16];
  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_q[$];
  logic [TL-1:0]   last_tag;
  logic [XLEN-1:0] last_val;
  logic [1:0]      last_gid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // driver tasks
  task automatic set_req(input int i, input logic v, input logic [TL-1:0] t, input logic [XLEN-1:0] val);
    req_valid[i] = v;
    req_rob_tag[i*TL +: TL] = t;
    req_value[i*XLEN +: XLEN] = val;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, '0, '0);
  endtask

  // Inputs are already driven; check ack mid-cycle, then the registered bus after the edge.
  task automatic run_cycle(input string name, input logic [3:0] exp_ack);
    int g;
    logic [CW-1:0] exp_cdb;
    #1;
    check({name, " ack"}, 64'(req_ack), 64'(exp_ack));
    if (exp_ack != 4'b0) begin
      g = onehot_idx(exp_ack);
      last_tag = req_rob_tag[g*TL +: TL];
      last_val = req_value[g*XLEN +: XLEN];
      last_gid = 2'(g);
      exp_cdb = {1'b1, last_tag, last_val};
    end else begin
      exp_cdb = {1'b0, last_tag, last_val};
    end
    exp_q.push_back(exp_cdb);
    @(posedge clock); #1;
    check({name, " cdb"}, 64'(cdb_data), 64'(exp_q.pop_front()));
    check({name, " gid"}, 64'(grant_id), 64'(last_gid));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    kill = 1'b0;
    head = 3'd1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'(i + 1), 32'hDEAD_0000 + 32'(i));
    @(posedge clock); #1;
    check("reset ack", 64'(req_ack), 64'd0);
    @(posedge clock); #1;
    check("reset cdb", 64'(cdb_data), 64'd0);
    check("reset gid", 64'(grant_id), 64'd0);
    check("reset starve", 64'(starve_flag), 64'd0);
    reset = 1'b0;
    clear_reqs();
    last_tag = '0;
    last_val = '0;
    last_gid = '0;
    exp_q.delete();
  endtask

  logic [3:0] exp_ack;

  initial begin
    reset = 1'b1;
    kill = 1'b0;
    head = '0;
    req_valid = '0;
    req_rob_tag = '0;
    req_value = '0;

    //            head  kill valid    {t3,t2,t1,t0}              rr       age
    vecs[0]  = '{3'd1, 1'b0, 4'b0101, {3'd0, 3'd2, 3'd0, 3'd3}, 4'b0001, 4'b0100};
    vecs[1]  = '{3'd4, 1'b0, 4'b1010, {3'd4, 3'd0, 3'd1, 3'd0}, 4'b0010, 4'b1000};
    vecs[2]  = '{3'd4, 1'b0, 4'b0010, {3'd0, 3'd0, 3'd1, 3'd0}, 4'b0010, 4'b0010};
    vecs[3]  = '{3'd1, 1'b1, 4'b0011, {3'd0, 3'd0, 3'd2, 3'd1}, 4'b0000, 4'b0000};
    vecs[4]  = '{3'd1, 1'b0, 4'b0011, {3'd0, 3'd0, 3'd2, 3'd1}, 4'b0001, 4'b0001};
    vecs[5]  = '{3'd1, 1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 4'b0000};
    vecs[6]  = '{3'd1, 1'b0, 4'b1111, {3'd1, 3'd4, 3'd3, 3'd2}, 4'b0010, 4'b1000};
    vecs[7]  = '{3'd1, 1'b0, 4'b1111, {3'd1, 3'd4, 3'd3, 3'd2}, 4'b0100, 4'b1000};
    vecs[8]  = '{3'd3, 1'b0, 4'b1001, {3'd3, 3'd0, 3'd0, 3'd4}, 4'b1000, 4'b1000};
    vecs[9]  = '{3'd3, 1'b0, 4'b1001, {3'd3, 3'd0, 3'd0, 3'd4}, 4'b0001, 4'b1000};
    vecs[10] = '{3'd1, 1'b0, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 4'b0000};
    vecs[11] = '{3'd2, 1'b0, 4'b0110, {3'd0, 3'd0, 3'd2, 3'd0}, 4'b0010, 4'b0010};
    vecs[12] = '{3'd1, 1'b0, 4'b0110, {3'd0, 3'd3, 3'd3, 3'd0}, 4'b0100, 4'b0010};
    vecs[13] = '{3'd2, 1'b0, 4'b1101, {3'd2, 3'd4, 3'd0, 3'd1}, 4'b1000, 4'b1000};
    vecs[14] = '{3'd3, 1'b0, 4'b0011, {3'd0, 3'd0, 3'd2, 3'd1}, 4'b0001, 4'b0001};
    vecs[15] = '{3'd4, 1'b0, 4'b0110, {3'd0, 3'd4, 3'd3, 3'd0}, 4'b0010, 4'b0100};

    @(posedge clock); #1;
    do_reset();

    // table-driven vectors
    for (int n = 0; n < 16; n++) begin
      head = vecs[n].head;
      kill = vecs[n].kill;
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, vecs[n].valid[i], vecs[n].tags[i*TL +: TL], 32'hA000_0000 | 32'(n << 8) | 32'(i));
`ifdef CDB_AGE_PRIORITY_EN
      exp_ack = vecs[n].ack_age;
`else
      exp_ack = vecs[n].ack_rr;
`endif
      run_cycle($sformatf("vec%0d", n), exp_ack);
    end
    kill = 1'b0;

    // all ports continuously valid: rotation, or port 3 starving behind older tags
    do_reset();
    head = 3'd1;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, 1'b1, 3'(i + 1), 32'hB000_0000 | 32'(c << 8) | 32'(i));
`ifdef CDB_AGE_PRIORITY_EN
      exp_ack = 4'b0001;
      run_cycle($sformatf("stream%0d", c), exp_ack);
      check($sformatf("stream%0d starve", c), 64'(starve_flag), 64'(c >= 7));
`else
      exp_ack = 4'(1 << (c % 4));
      run_cycle($sformatf("stream%0d", c), exp_ack);
      check($sformatf("stream%0d starve", c), 64'(starve_flag), 64'd0);
`endif
    end

    // kill held: port 2 waits until the counter saturates, then is granted
    do_reset();
    head = 3'd1;
    set_req(2, 1'b1, 3'd3, 32'hC0DE_0002);
    kill = 1'b1;
    for (int c = 0; c < 9; c++) begin
      run_cycle($sformatf("kill%0d", c), 4'b0000);
      check($sformatf("kill%0d starve", c), 64'(starve_flag), 64'(c >= 7));
    end
    kill = 1'b0;
    run_cycle("kill_release", 4'b0100);
    check("kill_release starve", 64'(starve_flag), 64'd0);

    // tag 0 is never eligible and never accumulates wait time
    clear_reqs();
    set_req(0, 1'b1, 3'd0, 32'h0000_BEEF);
    for (int c = 0; c < 10; c++) begin
      run_cycle($sformatf("tag0_%0d", c), 4'b0000);
      check($sformatf("tag0_%0d starve", c), 64'(starve_flag), 64'd0);
    end

    // reset (with kill) right after a grant to port 1
    clear_reqs();
    head = 3'd1;
    set_req(1, 1'b1, 3'd2, 32'h1111_0001);
    run_cycle("pre_reset", 4'b0010);
    reset = 1'b1;
    kill = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'(i + 1), 32'h2222_0000 + 32'(i));
    #1;
    check("mid_reset ack", 64'(req_ack), 64'd0);
    @(posedge clock); #1;
    check("post_reset cdb", 64'(cdb_data), 64'd0);
    check("post_reset gid", 64'(grant_id), 64'd0);
    check("post_reset starve", 64'(starve_flag), 64'd0);
    reset = 1'b0;
    kill = 1'b0;
    last_tag = '0;
    last_val = '0;
    last_gid = '0;
    clear_reqs();
    set_req(1, 1'b1, 3'd2, 32'h3333_0001);
    set_req(3, 1'b1, 3'd3, 32'h3333_0003);
    run_cycle("after_reset", 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
